fft16_seq: RTL and testbench
============================

# fft16_seq

Address and control sequencer for the 16-point radix-2 DIT FFT datapath. It drives one shared butterfly unit across 4 stages × 8 butterflies. For each butterfly it generates data-RAM read and write addresses and the twiddle-ROM address. It stalls between stages until the butterfly pipeline has drained, and uses a start/done handshake toward the system controller. Data input to the RAM is already bit-reversed; results are in natural order in place.

## Interface
- BF_LAT, 2, butterfly pipeline latency in cycles, from RAM read data valid to result valid; legal range 1..6
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request one transform; sampled only in IDLE
- inv  in  1  inverse-transform request, captured with start (used only with FFT16_SEQ_INV_EN)
- busy  out  1  high from first RUN cycle through last DRAIN cycle
- done  out  1  one-cycle pulse after final write
- stage  out  2  current stage index s
- rd_en  out  1  read strobe for both RAM ports
- rd_addr_a, rd_addr_b  out  4 each  butterfly operand addresses
- tw_addr  out  3  twiddle index into W16^0..W16^7, aligned with rd_en
- tw_conj  out  1  conjugate-twiddle flag, aligned with tw_addr
- wr_en  out  1  write strobe for both RAM ports
- wr_addr_a, wr_addr_b  out  4 each  result addresses

## Operation
- FSM states:
  - IDLE: start=1 → RUN with s=0, k=0.
  - RUN: issue butterfly k. If k=7 → DRAIN; otherwise k+1.
  - DRAIN: lasts D=BF_LAT+1 cycles. Then → RUN with s+1 and k=0, or → DONE when s=3.
  - DONE: one cycle, then → IDLE.
- Address generation for stage s, butterfly k (0..7):
  - span=2^s, pos=k mod span, grp=k>>s
  - rd_addr_a = grp·2^(s+1)+pos
  - rd_addr_b = rd_addr_a+span
  - tw_addr = pos<<(3−s)
  - All arithmetic is 4-bit unsigned and never overflows.
- rd_en=1 in every RUN cycle only.
- Write addresses are the read addresses delayed D cycles, through a D-deep shift register. wr_en is rd_en delayed D cycles.
- start while not IDLE (including DONE) is ignored. inv is captured only on an accepted start.
- rst, at any time including mid-transform: all outputs go to 0 immediately, state goes to IDLE, counters and delay line clear, and pending writes are discarded. The RAM contents are then undefined; the next start recomputes from whatever the RAM holds.

## Timing
- Reset values: busy, done, rd_en, wr_en, tw_conj = 0; stage and all addresses = 0.
- Cycle 0 is start sampled high in IDLE.
- Stage s RUN occupies cycles 1+s·(8+D) .. 8+s·(8+D).
- A read issued at cycle t is written at t+D. This assumes a synchronous RAM with 1-cycle read latency plus BF_LAT.
- DRAIN guarantees the last write of stage s (cycle 8+s·(8+D)+D) lands before the first read of stage s+1.
- busy is high on cycles 1..4·(8+D). done pulses on cycle 4·(8+D)+1.
  - With BF_LAT=2: busy on cycles 1..44, done on cycle 45.
- Back-to-back: the earliest next start is sampled in IDLE at cycle 4·(8+D)+2.

## Configuration
- FFT16_SEQ_INV_EN defined:
  - inv is latched on accepted start.
  - tw_conj = latched inv on every RUN cycle; the butterfly conjugates the twiddle, giving an unscaled IFFT.
- FFT16_SEQ_INV_EN undefined:
  - inv is ignored and tw_conj is held 0.
  - Ports are unchanged.

## Structure
- Shared package fft16_pkg contains:
  - N=16, LOG2N=4, TW_AW=3
  - state enum {IDLE, RUN, DRAIN, DONE}
  - address function bf_addr(s, k) returning rd_addr_a
- One sub-module, fft16_seq_dly: parameterised-depth shift register carrying {rd_en, rd_addr_a, rd_addr_b} to the write side. It clears on rst.

## Test plan
- Reset mid-RUN:
  - Stimulus: assert rst during stage 1, k=3.
  - Response: all outputs are 0 in the same cycle; no wr_en afterwards; start after release restarts at s=0.
- Nominal run, BF_LAT=2, start at cycle 0:
  - Stage 0: rd_addr_a/b sequence (0,1),(2,3)…(14,15), tw_addr all 0.
  - Stage 3: (0,8),(1,9)…(7,15), tw_addr 0..7.
  - done pulses at cycle 45.
- Write alignment:
  - Every wr_en is exactly 3 cycles after its rd_en, with matching addresses.
  - No stage s+1 read occurs at or before the last stage s write.
- Stage 2 spot check: k=5 gives rd_addr_a=9, rd_addr_b=13, tw_addr=2.
- start held high throughout:
  - Only one transform per IDLE visit.
  - start during busy and during DONE is ignored; the second transform begins at cycle 47.
- FFT16_SEQ_INV_EN:
  - start with inv=1 → tw_conj=1 on all 32 RUN cycles.
  - Without the macro → tw_conj=0 throughout.

Source files
------------

// File: rtl/fft16_pkg.sv
// Shared types and address helpers for the 16-point radix-2 DIT FFT sequencer.
package fft16_pkg;

  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int TW_AW = 3;
  localparam int AW    = $clog2(N);
  localparam int SW    = $clog2(LOG2N);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // Upper operand address of butterfly k in stage s: grp*2^(s+1) + pos.
  function automatic logic [AW-1:0] bf_addr(input logic [SW-1:0] s, input logic [2:0] k);
    logic [AW-1:0] span, pos, grp;
    span = 4'd1 << s;
    pos  = {1'b0, k} & (span - 4'd1);
    grp  = {1'b0, k} >> s;
    return (grp << ({1'b0, s} + 3'd1)) + pos;
  endfunction

  function automatic logic [TW_AW-1:0] bf_tw(input logic [SW-1:0] s, input logic [2:0] k);
    logic [TW_AW-1:0] pos;
    pos = k & ((3'd1 << s) - 3'd1);
    return pos << (2'd3 - s);
  endfunction

endpackage

// File: rtl/fft16_seq_dly.sv
// Clearable DEPTH-stage shift register; carries read strobe and addresses to the write side.
module fft16_seq_dly #(
  parameter int DEPTH = 3,
  parameter int W     = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fft16_seq.sv
// Address/control sequencer for a shared FFT16 butterfly; writes land BF_LAT+1 cycles after reads.
// Optional FFT16_SEQ_INV_EN: latch inv on start and drive tw_conj during RUN for the inverse transform.
module fft16_seq
  import fft16_pkg::*;
#(
  parameter int BF_LAT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             inv_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [SW-1:0]    stage_o,
  output logic             rd_en_o,
  output logic [AW-1:0]    rd_addr_a_o,
  output logic [AW-1:0]    rd_addr_b_o,
  output logic [TW_AW-1:0] tw_addr_o,
  output logic             tw_conj_o,
  output logic             wr_en_o,
  output logic [AW-1:0]    wr_addr_a_o,
  output logic [AW-1:0]    wr_addr_b_o
);

  localparam int D = BF_LAT + 1;

  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    k_q, k_d;
  logic [2:0]    dcnt_q, dcnt_d;
  logic          run_d, conj_d;

  logic             busy_q, done_q, rd_en_q, conj_q;
  logic [AW-1:0]    rd_a_q, rd_b_q;
  logic [TW_AW-1:0] tw_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        s_d     = '0;
        k_d     = '0;
      end
      RUN: if (k_q == 3'd7) begin
        state_d = DRAIN;
        dcnt_d  = '0;
      end else begin
        k_d = k_q + 3'd1;
      end
      // Hold off the next stage until the last write of this one has landed.
      DRAIN: if (dcnt_q == 3'(D - 1)) begin
        if (s_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          s_d     = s_q + 2'd1;
          k_d     = '0;
        end
      end else begin
        dcnt_d = dcnt_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign run_d = (state_d == RUN);

`ifdef FFT16_SEQ_INV_EN
  logic inv_q, inv_d;
  assign inv_d  = (state_q == IDLE && start_i) ? inv_i : inv_q;
  assign conj_d = run_d & inv_d;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) inv_q <= 1'b0;
    else       inv_q <= inv_d;
  end
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign conj_d     = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      conj_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= run_d || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
      rd_en_q <= run_d;
      rd_a_q  <= run_d ? bf_addr(s_d, k_d) : '0;
      rd_b_q  <= run_d ? bf_addr(s_d, k_d) + (4'd1 << s_d) : '0;
      tw_q    <= run_d ? bf_tw(s_d, k_d) : '0;
      conj_q  <= conj_d;
    end
  end

  logic [2*AW:0] wr_bus;

  fft16_seq_dly #(
    .DEPTH(D),
    .W    (2*AW + 1)
  ) u_dly (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  ({rd_en_q, rd_a_q, rd_b_q}),
    .q_o  (wr_bus)
  );

  assign wr_en_o     = wr_bus[2*AW];
  assign wr_addr_a_o = wr_bus[2*AW-1:AW];
  assign wr_addr_b_o = wr_bus[AW-1:0];

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign stage_o     = s_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_a_o = rd_a_q;
  assign rd_addr_b_o = rd_b_q;
  assign tw_addr_o   = tw_q;
  assign tw_conj_o   = conj_q;

endmodule

// File: tb/tb_fft16_seq.sv
// Scoreboard bench for fft16_seq: expected reads/writes are queued when start is accepted.
module tb_fft16_seq;

  localparam int BF_LAT = 2;
  localparam int D      = BF_LAT + 1;
  localparam int PER    = 8 + D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       inv = 1'b0;
  logic       busy, done, rd_en, tw_conj, wr_en;
  logic [1:0] stage;
  logic [3:0] rd_a, rd_b, wr_a, wr_b;
  logic [2:0] tw;

  fft16_seq #(.BF_LAT(BF_LAT)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .inv_i      (inv),
    .busy_o     (busy),
    .done_o     (done),
    .stage_o    (stage),
    .rd_en_o    (rd_en),
    .rd_addr_a_o(rd_a),
    .rd_addr_b_o(rd_b),
    .tw_addr_o  (tw),
    .tw_conj_o  (tw_conj),
    .wr_en_o    (wr_en),
    .wr_addr_a_o(wr_a),
    .wr_addr_b_o(wr_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
    int s;
    int conj;
  } ev_t;

  ev_t rdq[$];
  ev_t wrq[$];

  int cyc = 0;
  int n_total = 0;
  int n_bad = 0;
  int idle_from = 0;
  int c0 = 0;
  bit cur_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    int  k;
    bit  exp_rd, exp_wr;
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_conj", tw_conj, 0);
      chk("rst_stage", stage, 0);
      chk("rst_addr", {rd_a, rd_b, wr_a, wr_b, tw}, 0);
      rdq.delete();
      wrq.delete();
      cur_vld   = 1'b0;
      idle_from = 0;
    end else begin
      if (start && cyc >= idle_from) begin
        c0        = cyc;
        cur_vld   = 1'b1;
        idle_from = cyc + 4 * PER + 2;
        for (int s = 0; s < 4; s++) begin
          k = 0;
          for (int grp = 0; grp < (8 >> s); grp++) begin
            for (int pos = 0; pos < (1 << s); pos++) begin
              e.cyc = c0 + 1 + s * PER + k;
              e.a   = grp * 2 * (1 << s) + pos;
              e.b   = e.a + (1 << s);
              e.tw  = pos * (8 >> s);
              e.s   = s;
`ifdef FFT16_SEQ_INV_EN
              e.conj = int'(inv);
`else
              e.conj = 0;
`endif
              rdq.push_back(e);
              e.cyc = e.cyc + D;
              wrq.push_back(e);
              k++;
            end
          end
        end
      end

      exp_rd = (rdq.size() > 0) && (rdq[0].cyc == cyc);
      chk("rd_en", rd_en, exp_rd);
      if (exp_rd) begin
        e = rdq.pop_front();
        chk("rd_addr_a", rd_a, e.a);
        chk("rd_addr_b", rd_b, e.b);
        chk("tw_addr", tw, e.tw);
        chk("stage", stage, e.s);
        chk("tw_conj", tw_conj, e.conj);
      end else begin
        chk("tw_conj_idle", tw_conj, 0);
      end

      exp_wr = (wrq.size() > 0) && (wrq[0].cyc == cyc);
      chk("wr_en", wr_en, exp_wr);
      if (exp_wr) begin
        e = wrq.pop_front();
        chk("wr_addr_a", wr_a, e.a);
        chk("wr_addr_b", wr_b, e.b);
      end

      chk("busy", busy, cur_vld && cyc >= c0 + 1 && cyc <= c0 + 4 * PER);
      chk("done", done, cur_vld && cyc == c0 + 4 * PER + 1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(2);

    // single transform with inv requested
    start = 1'b1;
    inv   = 1'b1;
    step(1);
    start = 1'b0;
    inv   = 1'b0;
    step(55);

    // start held high: second transform only after returning to IDLE
    start = 1'b1;
    step(60);
    start = 1'b0;
    step(45);

    // reset in stage 1, butterfly 3
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(14);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(5);

    // restart after reset
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(55);

    chk("rdq_left", rdq.size(), 0);
    chk("wrq_left", wrq.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
